// File: rtl/c5_pkg.sv
// Shared definitions for the c5 iterative divider: FSM states, datapath width
// and the divide-by-zero quotient constant.
package c5_pkg;

    localparam int C5_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } c5_div_state_e;

    localparam logic [C5_XLEN-1:0] C5_DIV_ZERO_QUO = '1;

endpackage

// File: rtl/c5_negate.sv
// c5 two's-complement negation: negated = ~value + 1 (the most negative value maps to itself).
module c5_negate
    import c5_pkg::*;
#(
    parameter int WIDTH = C5_XLEN
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] negated
);

    assign negated = ~value + 1'b1;

endmodule

// File: rtl/c5_divider.sv
// c5 iterative restoring divider, one quotient bit per clock, signed/unsigned.
// Optional build macro C5_DIV_ZERO_FAST_EN: divide-by-zero skips the iteration phase.
module c5_divider
    import c5_pkg::*;
#(
    parameter int WIDTH = C5_XLEN
) (
    input  logic             I_clk,
    input  logic             I_reset_n,
    input  logic             I_start,
    input  logic             I_signed,
    input  logic [WIDTH-1:0] I_a,
    input  logic [WIDTH-1:0] I_b,
    output logic             O_busy,
    output logic             O_done,
    output logic [WIDTH-1:0] O_quotient,
    output logic [WIDTH-1:0] O_remainder,
    output logic             O_div_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DIV_ZERO_QUO = {WIDTH{C5_DIV_ZERO_QUO[0]}};

    c5_div_state_e    state, state_next;
    logic [CNT_W-1:0] iter_cnt;
    logic             sign_a, sign_b, div_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic             b_zero;
    logic             start_sign_a, start_sign_b;
    logic [WIDTH-1:0] neg_a_in, neg_b_in, neg_a_out, neg_b_out;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    // Two negators are shared: operand magnitudes on entry, result sign fixup in FIX.
    always_comb begin
        neg_a_in = I_a;
        neg_b_in = I_b;
        if (state == FIX) begin
            neg_a_in = quo;
            neg_b_in = rem;
        end
    end

    c5_negate #(.WIDTH(WIDTH)) u_negate_a (.value(neg_a_in), .negated(neg_a_out));
    c5_negate #(.WIDTH(WIDTH)) u_negate_b (.value(neg_b_in), .negated(neg_b_out));

    assign b_zero       = (I_b == '0);
    assign start_sign_a = I_signed & I_a[WIDTH-1];
    assign start_sign_b = I_signed & I_b[WIDTH-1];
    assign a_mag_in     = start_sign_a ? neg_a_out : I_a;
    assign b_mag_in     = start_sign_b ? neg_b_out : I_b;

    // When the shifted remainder overflows WIDTH bits it always exceeds the divisor.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, b_mag};
    assign trial_ok  = rem_shift[WIDTH] | ~trial[WIDTH];

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (I_start) begin
`ifdef C5_DIV_ZERO_FAST_EN
                    state_next = b_zero ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (iter_cnt == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            iter_cnt    <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div_zero    <= 1'b0;
            a_raw       <= '0;
            b_mag       <= '0;
            quo         <= '0;
            rem         <= '0;
            O_done      <= 1'b0;
            O_quotient  <= '0;
            O_remainder <= '0;
            O_div_zero  <= 1'b0;
        end else begin
            O_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_start) begin
                        sign_a   <= start_sign_a;
                        sign_b   <= start_sign_b;
                        div_zero <= b_zero;
                        a_raw    <= I_a;
                        b_mag    <= b_mag_in;
                        quo      <= a_mag_in;
                        rem      <= '0;
                        iter_cnt <= '0;
                    end
                end
                CALC: begin
                    iter_cnt <= iter_cnt + 1'b1;
                    if (trial_ok) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                    end
                    quo <= {quo[WIDTH-2:0], trial_ok};
                end
                FIX: begin
                    O_done     <= 1'b1;
                    O_div_zero <= div_zero;
                    if (div_zero) begin
                        O_quotient  <= DIV_ZERO_QUO;
                        O_remainder <= a_raw;
                    end else begin
                        O_quotient  <= (sign_a ^ sign_b) ? neg_a_out : quo;
                        O_remainder <= sign_a ? neg_b_out : rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_busy = (state != IDLE);

endmodule
